// File: rtl/uart_rx_bridge_feeder.sv
// uart_rx_bridge_feeder: 8N1 UART receiver feeding a byte FIFO that drains
// into the USB bridge write port (uart_we / uart_di / uart_wait).
// A byte leaves the FIFO only once the bridge has released uart_wait, so a
// stalled bridge never loses data; bursts are absorbed up to FIFO_DEPTH.
module uart_rx_bridge_feeder #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            uart_rx,
    output logic                            uart_we,
    output logic [7:0]                      uart_di,
    input  logic                            uart_wait,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overrun,
    output logic                            framing_err,
    output logic                            rx_busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int LVL_W        = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_GUARD, OUT_BUSY} out_state_t;

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             framing_err_q, framing_err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    out_state_t       out_state_q, out_state_d;
    logic             uart_we_q, uart_we_d;
    logic [7:0]       uart_di_q, uart_di_d;
    logic             pop;
    logic             push_ok;

    // Two-flop synchronizer; idles high so reset looks like an idle line.
    always_comb begin
        sync1_d = uart_rx;
        sync2_d = sync1_q;
    end

    // RX FSM next-state: start detect, half-bit start check, 8 data bits, stop.
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (!sync2_q) rx_state_d = RX_START;
            RX_START: if (cnt_q == CNT_HALF) rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_q == CNT_FULL && bit_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (cnt_q == CNT_FULL) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // RX datapath: bit-period counter, bit index, LSB-first shift, push/error flags.
    always_comb begin
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        push_d        = 1'b0;
        framing_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            RX_START: begin
                cnt_d = (cnt_q == CNT_HALF) ? '0 : cnt_q + CNT_W'(1);
                bit_d = '0;
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d         = '0;
                    push_d        = sync2_q;
                    framing_err_d = !sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // FIFO bookkeeping: a pop in the same cycle frees a slot for a push into a full FIFO.
    always_comb begin
        push_ok   = push_q && ((level_q != LVL_FULL) || pop);
        overrun_d = push_q && !push_ok;
        wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Output FSM next-state: strobe, one guard cycle for the bridge, then wait for release.
    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            OUT_IDLE:  if (level_q != '0 && !uart_wait) out_state_d = OUT_GUARD;
            OUT_GUARD: out_state_d = OUT_BUSY;
            OUT_BUSY:  if (!uart_wait) out_state_d = OUT_IDLE;
            default:   out_state_d = OUT_IDLE;
        endcase
    end

    // Output FSM outputs: head byte presented with the strobe, popped only on release.
    always_comb begin
        uart_we_d = 1'b0;
        uart_di_d = uart_di_q;
        pop       = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (level_q != '0 && !uart_wait) begin
                    uart_we_d = 1'b1;
                    uart_di_d = mem_q[rd_ptr_q];
                end
            end
            OUT_BUSY: pop = !uart_wait;
            default:  pop = 1'b0;
        endcase
    end

    // Control and output registers; reset returns both FSMs to idle and empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_state_q    <= RX_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            push_q        <= 1'b0;
            framing_err_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overrun_q     <= 1'b0;
            out_state_q   <= OUT_IDLE;
            uart_we_q     <= 1'b0;
            uart_di_q     <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rx_state_q    <= rx_state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            push_q        <= push_d;
            framing_err_q <= framing_err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overrun_q     <= overrun_d;
            out_state_q   <= out_state_d;
            uart_we_q     <= uart_we_d;
            uart_di_q     <= uart_di_d;
        end
    end

    // Data storage: shift register and FIFO array carry no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign uart_we     = uart_we_q;
    assign uart_di     = uart_di_q;
    assign fifo_level  = level_q;
    assign overrun     = overrun_q;
    assign framing_err = framing_err_q;
    assign rx_busy     = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_bridge_feeder.sv
// Bench for uart_rx_bridge_feeder: 16 clocks per bit, 4-entry FIFO.
// Expected bytes are kept as a queue of frames sent with a valid stop bit;
// a bridge model stalls uart_wait for random or held periods.
module tb_uart_rx_bridge_feeder;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_we;
    logic [7:0] uart_di;
    logic       uart_wait = 1'b0;
    logic [2:0] fifo_level;
    logic       overrun;
    logic       framing_err;
    logic       rx_busy;

    uart_rx_bridge_feeder #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_we(uart_we),
        .uart_di(uart_di), .uart_wait(uart_wait), .fifo_level(fifo_level),
        .overrun(overrun), .framing_err(framing_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         n_strobes = 0;
    int         ovr_cnt = 0;
    int         fe_cnt = 0;
    int         peak_level = 0;
    bit         busy_seen = 1'b0;
    bit         active = 1'b0;
    logic [7:0] latched = 8'h00;
    logic [7:0] last_di = 8'h00;
    bit         bridge_hold = 1'b0;
    int         busy_left = 0;
    int         busy_max = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Per-cycle compare against the expected byte stream, then the bridge model.
    always @(negedge clk) begin
        if (reset) begin
            active    = 1'b0;
            uart_wait = 1'b0;
            busy_left = 0;
        end else begin
            if (uart_we) begin
                chk("we_while_wait", uart_wait, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got byte %02h expected no strobe", uart_di);
                end else begin
                    chk("strobe_byte", uart_di, exp_q.pop_front());
                end
                n_strobes++;
                latched = uart_di;
                last_di = uart_di;
                active  = 1'b1;
            end else if (active) begin
                if (uart_wait) chk("di_stable", uart_di, latched);
                else active = 1'b0;
            end
            if (overrun) ovr_cnt++;
            if (framing_err) fe_cnt++;
            if (rx_busy) busy_seen = 1'b1;
            if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
            chk("level_bound", (fifo_level <= 3'(DEPTH)), 1);
            if (bridge_hold) uart_wait = 1'b1;
            else if (uart_we) begin
                uart_wait = 1'b1;
                busy_left = (busy_max == 0) ? 0 : int'($urandom_range(busy_max, 0));
            end else if (busy_left > 0) busy_left--;
            else uart_wait = 1'b0;
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        settle(12);
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int k = 0;
        while (n_strobes < target && k < budget) begin
            settle(1);
            k++;
        end
        chk(name, n_strobes, target);
    endtask

    int n0, f0, o0, fe_exp, ngood;
    logic [7:0] rb;
    logic       rs;

    initial begin
        // Reset state
        settle(3);
        chk("rst_we", uart_we, 0);
        chk("rst_di", uart_di, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", rx_busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single byte straight through
        peak_level = 0;
        n0 = n_strobes;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_strobes(n0 + 1, 60, "t1_strobes");
        settle(5);
        chk("t1_peak_level", peak_level, 1);
        chk("t1_byte", last_di, 8'hA5);
        chk("t1_level_end", fifo_level, 0);

        // Stalled bridge fills the FIFO, then an extra byte overruns
        bridge_hold = 1'b1;
        settle(2);
        n0 = n_strobes;
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        settle(4);
        chk("t2_level_full", fifo_level, 4);
        chk("t2_no_strobe", n_strobes, n0);
        o0 = ovr_cnt;
        send_frame(8'h55, 1'b1);
        settle(4);
        chk("t3_overrun_once", ovr_cnt - o0, 1);
        chk("t3_level_still_full", fifo_level, 4);
        bridge_hold = 1'b0;
        wait_strobes(n0 + 4, 200, "t2_drain");
        settle(30);
        chk("t3_no_extra_strobe", n_strobes, n0 + 4);
        chk("t2_last_byte", last_di, 8'h04);
        chk("t2_level_empty", fifo_level, 0);

        // Framing error discards the byte; next byte is fine
        f0 = fe_cnt;
        n0 = n_strobes;
        send_frame(8'h3C, 1'b0);
        settle(4);
        chk("t4_framing_once", fe_cnt - f0, 1);
        chk("t4_level", fifo_level, 0);
        chk("t4_no_strobe", n_strobes, n0);
        exp_q.push_back(8'h3D);
        send_frame(8'h3D, 1'b1);
        wait_strobes(n0 + 1, 60, "t4_next_strobe");
        chk("t4_next_byte", last_di, 8'h3D);

        // Short low glitch on the idle line
        settle(5);
        busy_seen = 1'b0;
        f0 = fe_cnt;
        o0 = ovr_cnt;
        n0 = n_strobes;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        settle(30);
        chk("t5_busy_seen", busy_seen, 1);
        chk("t5_busy_end", rx_busy, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_no_error", fe_cnt - f0, 0);
        chk("t5_no_overrun", ovr_cnt - o0, 0);
        chk("t5_no_strobe", n_strobes, n0);

        // Reset mid-byte with two bytes queued
        bridge_hold = 1'b1;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        settle(2);
        chk("t6_level_before", fifo_level, 2);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        chk("t6_busy_before", rx_busy, 1);
        reset = 1'b1;
        uart_rx = 1'b1;
        bridge_hold = 1'b0;
        settle(1);
        exp_q.delete();
        chk("t6_we", uart_we, 0);
        chk("t6_di", uart_di, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_overrun", overrun, 0);
        chk("t6_framing", framing_err, 0);
        chk("t6_busy", rx_busy, 0);
        @(negedge clk);
        reset = 1'b0;
        n0 = n_strobes;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_strobes(n0 + 1, 60, "t6_after_strobe");
        chk("t6_after_byte", last_di, 8'h7E);
        settle(5);
        chk("t6_after_level", fifo_level, 0);

        // Random frames, random stop errors, random bridge stalls
        busy_max = 30;
        fe_exp = 0;
        ngood = 0;
        f0 = fe_cnt;
        o0 = ovr_cnt;
        n0 = n_strobes;
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(7, 0) != 0);
            if (rs) begin
                exp_q.push_back(rb);
                ngood++;
            end else begin
                fe_exp++;
            end
            send_frame(rb, rs);
            settle(int'($urandom_range(10, 0)) + 1);
        end
        wait_strobes(n0 + ngood, 400, "rnd_strobes");
        settle(40);
        chk("rnd_framing", fe_cnt - f0, fe_exp);
        chk("rnd_overrun", ovr_cnt - o0, 0);
        chk("rnd_level", fifo_level, 0);
        chk("rnd_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
